// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU then 2x2 max pooling over a stream of conv output columns
module relu_maxpool_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS = 26,
    parameter int RELU_EN = 1,
    localparam int OUT_ROWS = (ROWS + 1) / 2,
    localparam int COL_W = $clog2(ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data [ROWS],
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data [OUT_ROWS],
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [COL_W-1:0]             out_col
);
    logic signed [DATA_WIDTH-1:0] cond [ROWS];
    logic signed [DATA_WIDTH-1:0] hold [ROWS];
    logic signed [DATA_WIDTH-1:0] pooled [OUT_ROWS];
    logic odd, accept, emit;

    function automatic logic signed [DATA_WIDTH-1:0] max2(input logic signed [DATA_WIDTH-1:0] a,
                                                          input logic signed [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    assign emit = accept && (odd || in_last);

    for (genvar i = 0; i < ROWS; i++) begin : g_cond
        assign cond[i] = (RELU_EN != 0 && in_data[i] < 0) ? '0 : in_data[i];
    end

    for (genvar k = 0; k < OUT_ROWS; k++) begin : g_pool
        logic signed [DATA_WIDTH-1:0] col_max, hold_max;
        if (2 * k + 1 < ROWS) begin : g_pair
            assign col_max = max2(cond[2*k], cond[2*k+1]);
            assign hold_max = max2(hold[2*k], hold[2*k+1]);
        end else begin : g_single
            assign col_max = cond[2*k];
            assign hold_max = hold[2*k];
        end
        assign pooled[k] = odd ? max2(col_max, hold_max) : col_max;
    end

    // Output register, column counter, pairing parity and held even column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_col   <= '0;
            hold      <= '{default: '0};
            out_data  <= '{default: '0};
        end else begin
            if (out_valid && out_ready) out_col <= out_last ? '0 : out_col + 1'b1;
            if (emit) begin
                out_data  <= pooled;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) odd <= !odd && !in_last;
            if (accept && !odd && !in_last) hold <= cond;
        end
    end
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: three configurations checked against a window-max reference model
module tb_relu_maxpool_2x2;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
    logic signed [31:0] d4 [4];
    logic signed [31:0] d5 [5];
    logic signed [31:0] o0 [2];
    logic signed [31:0] o1 [2];
    logic signed [31:0] o2 [3];
    logic r0, r1, r2, v0, v1, v2, l0, l1, l2;
    logic [2:0] c0, c1, c2;

    always #5 clk = ~clk;

    relu_maxpool_2x2 #(.DATA_WIDTH(32), .ROWS(4), .RELU_EN(1)) u0 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(in_valid), .in_last(in_last), .in_ready(r0),
        .out_data(o0), .out_valid(v0), .out_last(l0), .out_ready(out_ready), .out_col(c0));
    relu_maxpool_2x2 #(.DATA_WIDTH(32), .ROWS(4), .RELU_EN(0)) u1 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(in_valid), .in_last(in_last), .in_ready(r1),
        .out_data(o1), .out_valid(v1), .out_last(l1), .out_ready(out_ready), .out_col(c1));
    relu_maxpool_2x2 #(.DATA_WIDTH(32), .ROWS(5), .RELU_EN(1)) u2 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(in_valid), .in_last(in_last), .in_ready(r2),
        .out_data(o2), .out_valid(v2), .out_last(l2), .out_ready(out_ready), .out_col(c2));

    typedef struct {
        int d [3][3];
        bit last;
        int col;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0;
    int col [5];
    int prev [5];
    bit have = 0;
    int fcnt = 0;
    logic signed [31:0] snap0, snap1;

    function automatic int rows(input int j); return j == 2 ? 5 : 4; endfunction
    function automatic bit en(input int j); return j != 1; endfunction
    function automatic int rl(input int x, input bit e); return (e && x < 0) ? 0 : x; endfunction
    function automatic int mx(input int a, input int b); return a > b ? a : b; endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_out(input bit last);
        exp_t e;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++) begin
                int m;
                m = 0;
                if (2 * k < rows(j)) begin
                    m = rl(col[2*k], en(j));
                    for (int r = 2 * k; r <= 2 * k + 1; r++)
                        if (r < rows(j)) begin
                            m = mx(m, rl(col[r], en(j)));
                            if (have) m = mx(m, rl(prev[r], en(j)));
                        end
                end
                e.d[j][k] = m;
            end
        e.last = last;
        e.col = fcnt;
        fcnt = last ? 0 : fcnt + 1;
        q.push_back(e);
    endtask

    task automatic step(input bit v, input bit last, input bit rdy);
        bit ire, acc;
        exp_t h;
        @(negedge clk);
        in_valid = v;
        in_last = last;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) d4[i] = col[i];
        for (int i = 0; i < 5; i++) d5[i] = col[i];
        #1;
        ire = (q.size() == 0) || rdy;
        chk("in_ready0", r0, ire);
        chk("in_ready2", r2, ire);
        chk("out_valid0", v0, q.size() > 0);
        chk("out_valid1", v1, q.size() > 0);
        chk("out_valid2", v2, q.size() > 0);
        if (q.size() > 0) begin
            h = q[0];
            for (int k = 0; k < 2; k++) chk("data_relu4", o0[k], h.d[0][k]);
            for (int k = 0; k < 2; k++) chk("data_norelu4", o1[k], h.d[1][k]);
            for (int k = 0; k < 3; k++) chk("data_relu5", o2[k], h.d[2][k]);
            chk("out_last0", l0, h.last);
            chk("out_last2", l2, h.last);
            chk("out_col0", c0, h.col);
            chk("out_col2", c2, h.col);
            if (rdy) void'(q.pop_front());
        end
        acc = v && ire;
        if (acc) begin
            if (have || last) push_out(last);
            if (!have && !last) prev = col;
            have = !have && !last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        #1;
        chk("rst_valid", v0, 0);
        chk("rst_last", l0, 0);
        chk("rst_col", c0, 0);
        chk("rst_data0", o0[0], 0);
        chk("rst_data1", o0[1], 0);
        chk("rst_data5", o2[2], 0);
        @(negedge clk);
        rst = 0;
        q.delete();
        have = 0;
        fcnt = 0;
        #1;
        chk("rst_in_ready", r0, 1);
    endtask

    initial begin
        col = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) d4[i] = 0;
        for (int i = 0; i < 5; i++) d5[i] = 0;
        do_reset();

        col = '{5, -3, 7, 1, 0};
        step(1, 0, 1);
        col = '{2, 9, -8, 4, 0};
        step(1, 1, 1);
        chk("pair_k0", o0[0], 9);
        chk("pair_k1", o0[1], 7);
        chk("pair_last", l0, 1);
        step(0, 0, 1);

        col = '{-1, -2, -3, -4, -5};
        step(1, 0, 1);
        step(1, 1, 1);
        chk("neg_relu_k0", o0[0], 0);
        chk("neg_relu_k1", o0[1], 0);
        chk("neg_norelu_k0", o1[0], -1);
        chk("neg_norelu_k1", o1[1], -3);
        step(0, 0, 1);

        col = '{3, 1, 4, 1, 5};
        step(1, 0, 1);
        col = '{9, 2, 6, 5, 3};
        step(1, 0, 1);
        col = '{5, 8, 9, 7, 9};
        step(1, 1, 1);
        chk("odd_frame_col", c0, 1);
        chk("odd_frame_last", l0, 1);
        chk("odd_frame_k0", o0[0], 8);
        step(0, 0, 1);
        chk("col_wrap", c0, 0);

        col = '{10, 20, 30, 40, 50};
        step(1, 0, 1);
        col = '{11, 21, 31, 41, 51};
        step(1, 0, 0);
        snap0 = o0[0];
        snap1 = o0[1];
        col = '{70, 80, 90, 99, 1};
        for (int s = 0; s < 5; s++) begin
            step(1, 1, 0);
            chk("stall_k0", o0[0], snap0);
            chk("stall_k1", o0[1], snap1);
            chk("stall_ready", r0, 0);
        end
        step(1, 1, 1);
        chk("no_bubble_valid", v0, 1);
        chk("no_bubble_k0", o0[0], 80);
        step(0, 0, 1);

        col = '{500, 500, 500, 500, 500};
        step(1, 0, 1);
        do_reset();
        col = '{1, 2, 3, 4, 5};
        step(1, 0, 1);
        col = '{6, 1, 2, 3, 4};
        step(1, 1, 1);
        chk("post_rst_k0", o0[0], 6);
        chk("post_rst_k1", o0[1], 4);
        step(0, 0, 1);

        col = '{1, 2, 3, 4, 6};
        step(1, 0, 1);
        col = '{0, 0, 0, 0, -9};
        step(1, 1, 1);
        chk("odd_rows_k0", o2[0], 2);
        chk("odd_rows_k1", o2[1], 4);
        chk("odd_rows_k2", o2[2], 6);
        step(0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 5; i++) col[i] = int'($urandom_range(200)) - 100;
            step($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(3) != 0);
        end
        for (int n = 0; n < 3; n++) step(0, 0, 1);
        chk("drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/relu_maxpool_2x2.md
RELU_MAXPOOL_2X2 -- requirements
Module: relu_maxpool_2x2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed conv-result width per element.
REQ-002 SHALL have parameter ROWS, default 26, elements per input column, equal to the conv column height IMAGE_SIZE-KERNEL_SIZE+1.
REQ-003 SHALL have parameter RELU_EN, default 1; when 1, ReLU is applied before pooling.
REQ-004 SHALL derive localparam OUT_ROWS = (ROWS+1)/2.
REQ-005 SHALL derive localparam COL_W = $clog2(ROWS+1).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_data  input  DATA_WIDTH x ROWS (unpacked array)  one conv output column, signed.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_last  input  1  in_data is the last column of the frame; qualified by in_valid.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 out_data  output  DATA_WIDTH x OUT_ROWS  pooled column, signed.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_last  output  1  out_data is the last pooled column of the frame.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_col  output  COL_W  index of the current pooled column within the frame.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready, combinational.
REQ-018 Element conditioning SHALL be: r(x) = (RELU_EN && x<0) ? 0 : x; signed compare; no width change.
REQ-019 SHALL keep a parity bit odd, reset 0, plus a ROWS-wide hold register of conditioned elements.
REQ-020 Accept with odd=0 and in_last=0 SHALL store r(in_data) into hold, set odd=1, and emit nothing.
REQ-021 Accept with odd=1 SHALL emit out_data[k] = max(hold[2k], hold[2k+1], r(in[2k]), r(in[2k+1])), then set odd=0.
REQ-022 Accept with odd=0 and in_last=1 (odd column count) SHALL emit out_data[k] = max(r(in[2k]), r(in[2k+1])) and keep odd=0.
REQ-023 For odd ROWS, the unpaired last row SHALL be pooled from its available elements only, i.e. no padding value takes part.
REQ-024 Emission SHALL load out_data, out_last=in_last and out_valid=1 on the clock edge of the accept, giving one cycle of latency.
REQ-025 out_valid, out_data, out_last and out_col SHALL hold stable while out_valid && !out_ready.
REQ-026 out_valid SHALL clear on out_ready unless a new emission happens in the same cycle; a simultaneous handshake-out and emission SHALL reload without a bubble.
REQ-027 out_col SHALL increment after each out handshake, and SHALL return to 0 after the out handshake with out_last=1.
REQ-028 Accepting in_last SHALL force odd=0 afterwards, so the next frame starts pairing fresh.
REQ-029 in_data SHALL be ignored when in_valid=0; in_last SHALL be ignored when in_valid=0.

Reset
REQ-030 On rst: out_valid=0, out_last=0, out_col=0, odd=0, out_data all 0, hold all 0; in_ready=1 in the cycle after release.
REQ-031 rst mid-frame SHALL discard hold and any pending output; the first column accepted after reset is treated as even.

Verification
REQ-032 Two columns, ROWS=4, RELU_EN=1: col0 {5,-3,7,1}, col1 {2,9,-8,4} -> one output {9,7} with out_last per in_last, one cycle after col1 is accepted.
REQ-033 RELU_EN=1, all inputs negative {-1,-2,-3,-4} x 2 columns -> out_data {0,0}; with RELU_EN=0 -> {-1,-3}.
REQ-034 Three-column frame with in_last on col2 -> two outputs; the second pools col2 alone, has out_last=1 and out_col=1; out_col then returns to 0.
REQ-035 Hold out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, in_ready=0, no input lost; releasing it gives back-to-back outputs with no bubble.
REQ-036 Assert rst after col0 of a pair -> out_valid=0; the next two columns pair with each other, with no contribution from the pre-reset column.
REQ-037 ROWS=5 (odd): col0 {1,2,3,4,6}, col1 {0,0,0,0,-9} with RELU_EN=1 -> {2,4,6}.
